// File: rtl/bp_pkg.sv
// Package: bp_pkg
// Shared types and helpers for the branch-predictor table access scheduler.
//   HIST_W_DEF        default global-history width per thread
//   SNT/WNT/WT/ST     2-bit saturating counter encodings
//   sat_inc/sat_dec   saturating counter update helpers
//   state_t           scheduler FSM state encoding
//   entry_t           in-flight queue entry {idx, pred} at the default width
package bp_pkg;

  localparam int HIST_W_DEF = 4;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LK_RESP = 2'd1,
    UP_RD   = 2'd2,
    UP_WR   = 2'd3
  } state_t;

  typedef struct packed {
    logic [HIST_W_DEF:0] idx;
    logic                pred;
  } entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_sched_fifo.sv
// Module: bp_sched_fifo
// Single-clock synchronous FIFO holding in-flight predictions of one thread.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-low clear (empties the FIFO)
//   push   in   write din (ignored when full)
//   pop    in   drop the head entry (ignored when empty)
//   din    in   W-bit entry
//   dout   out  head entry (valid while !empty)
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
module bp_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no clear: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_access_sched.sv
// Module: bp_access_sched
// Shares one external 2-bit-counter pattern history table (1-cycle read
// latency) between two branch streams. Sequences lookups (read -> prediction)
// and resolves (read-modify-write of the counter), keeps a global history and
// an in-flight queue per thread, and counts mispredictions per thread.
// Optional feature macro: BP_SCHED_STATS_EN (per-thread lookup counters).
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   lk_valid/lk_ready     lookup request / single-cycle grant, bit = thread
//   pred_valid/pred_taken prediction pulse and direction per thread
//   rs_valid/rs_taken     resolve request for the oldest in-flight branch
//   rs_ready              single-cycle resolve grant per thread
//   tbl_rd_en/tbl_we      table read / write strobes
//   tbl_addr/tbl_wdata    table index {tid, hist} / counter write value
//   tbl_rdata             counter read data, valid the cycle after tbl_rd_en
//   mispredict_cnt        {thread1, thread0} saturating mispredict counts
//   lookup_cnt            {thread1, thread0} accepted lookups (0 without stats)
//   dbg_state             current FSM state
//
// Handshake: a request is accepted in the cycle where valid[t] and ready[t]
// are both high. Ready is a combinational single-cycle grant raised only in
// IDLE and only to an eligible thread; the requester holds valid (and
// rs_taken) until it sees ready.
module bp_access_sched
  import bp_pkg::*;
#(
  parameter int HIST_W = HIST_W_DEF,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         lk_valid,
  output logic [1:0]         lk_ready,
  output logic [1:0]         pred_valid,
  output logic [1:0]         pred_taken,
  input  logic [1:0]         rs_valid,
  input  logic [1:0]         rs_taken,
  output logic [1:0]         rs_ready,
  output logic               tbl_rd_en,
  output logic               tbl_we,
  output logic [HIST_W:0]    tbl_addr,
  output logic [1:0]         tbl_wdata,
  input  logic [1:0]         tbl_rdata,
  output logic [2*CNT_W-1:0] mispredict_cnt,
  output logic [2*CNT_W-1:0] lookup_cnt,
  output state_t             dbg_state
);

  localparam int EW = HIST_W + 2;

  state_t            state;
  logic              cur_tid;
  logic [HIST_W:0]   cur_idx;
  logic              cur_pred;
  logic              cur_taken;
  logic              rr;
  logic [HIST_W-1:0] hist   [2];
  logic [CNT_W-1:0]  mp_cnt [2];

  logic [1:0]        q_push, q_pop, q_full, q_empty;
  logic [EW-1:0]     q_din;
  logic [EW-1:0]     q_head [2];

  logic [1:0]        rs_elig, lk_elig;
  logic              grant_rs, grant_lk, gnt_tid;

  // Both eligible: take the thread rr favours; otherwise the only one eligible.
  function automatic logic pick(input logic [1:0] e, input logic r);
    return (e == 2'b11) ? r : e[1];
  endfunction

  // Resolves outrank lookups; reset gating keeps grants off while in reset.
  always_comb begin
    rs_elig  = rs_valid & ~q_empty;
    lk_elig  = lk_valid & ~q_full;
    grant_rs = reset && (state == IDLE) && (|rs_elig);
    grant_lk = reset && (state == IDLE) && !(|rs_elig) && (|lk_elig);
    gnt_tid  = (|rs_elig) ? pick(rs_elig, rr) : pick(lk_elig, rr);
  end

  assign rs_ready   = grant_rs ? {gnt_tid, ~gnt_tid} : 2'b00;
  assign lk_ready   = grant_lk ? {gnt_tid, ~gnt_tid} : 2'b00;
  assign pred_valid = (state == LK_RESP) ? {cur_tid, ~cur_tid} : 2'b00;
  assign pred_taken = pred_valid & {2{tbl_rdata[1]}};

  assign tbl_rd_en  = grant_lk || (state == UP_RD);
  assign tbl_we     = (state == UP_WR);
  assign tbl_addr   = grant_lk ? {gnt_tid, hist[gnt_tid]} :
                      (state == UP_RD || state == UP_WR) ? cur_idx : '0;
  assign tbl_wdata  = (state != UP_WR) ? 2'b00 :
                      cur_taken ? sat_inc(tbl_rdata) : sat_dec(tbl_rdata);

  assign q_push     = pred_valid;
  assign q_pop      = rs_ready;
  assign q_din      = {cur_idx, tbl_rdata[1]};

  assign mispredict_cnt = {mp_cnt[1], mp_cnt[0]};
  assign dbg_state      = state;

  for (genvar t = 0; t < 2; t++) begin : g_q
    bp_sched_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (q_push[t]),
      .pop   (q_pop[t]),
      .din   (q_din),
      .dout  (q_head[t]),
      .full  (q_full[t]),
      .empty (q_empty[t])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur_tid   <= 1'b0;
      cur_idx   <= '0;
      cur_pred  <= 1'b0;
      cur_taken <= 1'b0;
      rr        <= 1'b0;
      for (int t = 0; t < 2; t++) begin
        hist[t]   <= '0;
        mp_cnt[t] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (grant_rs) begin
            cur_tid   <= gnt_tid;
            cur_idx   <= q_head[gnt_tid][EW-1:1];
            cur_pred  <= q_head[gnt_tid][0];
            cur_taken <= rs_taken[gnt_tid];
            rr        <= ~gnt_tid;
            state     <= UP_RD;
          end else if (grant_lk) begin
            cur_tid   <= gnt_tid;
            cur_idx   <= {gnt_tid, hist[gnt_tid]};
            rr        <= ~gnt_tid;
            state     <= LK_RESP;
          end
        end
        LK_RESP: state <= IDLE;
        UP_RD:   state <= UP_WR;
        UP_WR: begin
          // History is non-speculative: it only advances on resolve.
          hist[cur_tid] <= {hist[cur_tid][HIST_W-2:0], cur_taken};
          if ((cur_taken != cur_pred) && (mp_cnt[cur_tid] != '1))
            mp_cnt[cur_tid] <= mp_cnt[cur_tid] + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BP_SCHED_STATS_EN
  logic [CNT_W-1:0] lk_cnt [2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lk_cnt[0] <= '0;
      lk_cnt[1] <= '0;
    end else if (grant_lk && (lk_cnt[gnt_tid] != '1)) begin
      lk_cnt[gnt_tid] <= lk_cnt[gnt_tid] + 1'b1;
    end
  end

  assign lookup_cnt = {lk_cnt[1], lk_cnt[0]};
`else
  assign lookup_cnt = '0;
`endif

endmodule

// File: tb/tb_bp_access_sched.sv
module tb_bp_access_sched;
  import bp_pkg::*;

  localparam int HIST_W = 4;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         lk_valid = 2'b00;
  logic [1:0]         rs_valid = 2'b00;
  logic [1:0]         rs_taken = 2'b00;
  logic [1:0]         lk_ready, pred_valid, pred_taken, rs_ready;
  logic               tbl_rd_en, tbl_we;
  logic [HIST_W:0]    tbl_addr;
  logic [1:0]         tbl_wdata;
  logic [1:0]         tbl_rdata;
  logic [2*CNT_W-1:0] mispredict_cnt, lookup_cnt;
  state_t             dbg_state;

  bp_access_sched #(.HIST_W(HIST_W), .DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .lk_valid       (lk_valid),
    .lk_ready       (lk_ready),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .rs_valid       (rs_valid),
    .rs_taken       (rs_taken),
    .rs_ready       (rs_ready),
    .tbl_rd_en      (tbl_rd_en),
    .tbl_we         (tbl_we),
    .tbl_addr       (tbl_addr),
    .tbl_wdata      (tbl_wdata),
    .tbl_rdata      (tbl_rdata),
    .mispredict_cnt (mispredict_cnt),
    .lookup_cnt     (lookup_cnt),
    .dbg_state      (dbg_state)
  );

  // ---------------- external table RAM model ----------------
  logic [1:0]      mem [32];
  logic            mem_clr = 1'b0;
  logic            pre_we = 1'b0;
  logic [HIST_W:0] pre_addr = '0;
  logic [1:0]      pre_data = 2'b00;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 2'b00;
      tbl_rdata <= 2'b00;
    end else begin
      if (tbl_rd_en) tbl_rdata <= mem[tbl_addr];
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else if (pre_we) mem[pre_addr] <= pre_data;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [3:0] gnt_q[$];   // {lk_ready, rs_ready}
  logic [3:0] pred_q[$];  // {pred_valid, pred_taken}
  logic [4:0] rd_q[$];    // tbl_addr on read strobe
  logic [6:0] wr_q[$];    // {tbl_addr, tbl_wdata} on write strobe

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s act=%0h exp=none t=%0t", name, act, $time);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (lk_ready != 2'b00 || rs_ready != 2'b00) begin
        if (gnt_q.size() == 0) unexpected("grant", {lk_ready, rs_ready});
        else chk("grant", {lk_ready, rs_ready}, gnt_q.pop_front());
      end
      if (pred_valid != 2'b00) begin
        if (pred_q.size() == 0) unexpected("pred", {pred_valid, pred_taken});
        else chk("pred", {pred_valid, pred_taken}, pred_q.pop_front());
      end else begin
        chk("pred_taken_idle", pred_taken, 2'b00);
      end
      if (tbl_rd_en) begin
        if (rd_q.size() == 0) unexpected("tbl_rd", tbl_addr);
        else chk("tbl_rd", tbl_addr, rd_q.pop_front());
      end
      if (tbl_we) begin
        if (wr_q.size() == 0) unexpected("tbl_wr", {tbl_addr, tbl_wdata});
        else chk("tbl_wr", {tbl_addr, tbl_wdata}, wr_q.pop_front());
      end else begin
        chk("wdata_idle", tbl_wdata, 2'b00);
      end
      if (!tbl_rd_en && !tbl_we) chk("addr_idle", tbl_addr, 5'd0);
    end
  end

  // ---------------- driver tasks ----------------
  logic [1:0] hold_lk = 2'b00;
  logic [1:0] hold_rs = 2'b00;

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue n0/n1 lookups and the resolves in rs, holding each request until granted.
  task automatic req(input int n0, input int n1, input logic [1:0] rs, input logic [1:0] tk);
    int c0 = n0;
    int c1 = n1;
    logic [1:0] rsp = rs;
    int guard = 0;
    rs_taken = tk;
    while ((c0 > 0 || c1 > 0 || rsp != 2'b00) && guard < 200) begin
      lk_valid = {c1 > 0, c0 > 0} | hold_lk;
      rs_valid = rsp | hold_rs;
      @(negedge clk);
      if (lk_ready[0]) c0--;
      if (lk_ready[1]) c1--;
      rsp = rsp & ~rs_ready;
      @(posedge clk);
      #1;
      guard++;
      lk_valid = {c1 > 0, c0 > 0} | hold_lk;
      rs_valid = rsp | hold_rs;
    end
    lk_valid = hold_lk;
    rs_valid = hold_rs;
    if (guard >= 200) unexpected("req_timeout", {c1[7:0], c0[7:0], 6'd0, rsp});
  endtask

  task automatic preload(input logic [4:0] a, input logic [1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we = 1'b1;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_lk_ready"}, lk_ready, 2'b00);
    chk({tag, "_rs_ready"}, rs_ready, 2'b00);
    chk({tag, "_pred"}, {pred_valid, pred_taken}, 4'b0000);
    chk({tag, "_tbl_strobes"}, {tbl_rd_en, tbl_we}, 2'b00);
    chk({tag, "_tbl_addr"}, tbl_addr, 5'd0);
    chk({tag, "_tbl_wdata"}, tbl_wdata, 2'b00);
    chk({tag, "_mispredict_cnt"}, mispredict_cnt, 32'd0);
    chk({tag, "_lookup_cnt"}, lookup_cnt, 32'd0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset with requests pending: nothing may be granted.
    mem_clr = 1'b1;
    lk_valid = 2'b11;
    rs_valid = 2'b11;
    settle(3);
    chk_outputs_zero("reset");
    lk_valid = 2'b00;
    rs_valid = 2'b00;
    mem_clr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    settle(1);

    // Lookup T0 on an all-zero table, then resolve taken (mispredict).
    gnt_q.push_back(4'b0100); rd_q.push_back(5'b00000); pred_q.push_back(4'b0100);
    req(1, 0, 2'b00, 2'b00);
    settle(2);
    gnt_q.push_back(4'b0001); rd_q.push_back(5'b00000); wr_q.push_back({5'b00000, 2'b01});
    req(0, 0, 2'b01, 2'b01);
    settle(3);
    chk("mp_after_first_resolve", mispredict_cnt, 32'h0000_0001);

    // Saturation at the top: counter 11, predicted taken, resolved taken.
    preload(5'b00001, 2'b11);
    gnt_q.push_back(4'b0100); rd_q.push_back(5'b00001); pred_q.push_back(4'b0101);
    req(1, 0, 2'b00, 2'b00);
    settle(2);
    gnt_q.push_back(4'b0001); rd_q.push_back(5'b00001); wr_q.push_back({5'b00001, 2'b11});
    req(0, 0, 2'b01, 2'b01);
    settle(3);
    // Saturation at the bottom: counter 00, predicted not-taken, resolved not-taken.
    preload(5'b00011, 2'b00);
    gnt_q.push_back(4'b0100); rd_q.push_back(5'b00011); pred_q.push_back(4'b0100);
    req(1, 0, 2'b00, 2'b00);
    settle(2);
    gnt_q.push_back(4'b0001); rd_q.push_back(5'b00011); wr_q.push_back({5'b00011, 2'b00});
    req(0, 0, 2'b01, 2'b00);
    settle(3);
    chk("mp_after_matches", mispredict_cnt, 32'h0000_0001);

    // Resolve on an empty T1 queue stalls.
    hold_rs = 2'b10;
    rs_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rs_stall_empty", rs_ready, 2'b00);
      @(posedge clk);
      #1;
    end
    hold_rs = 2'b00;
    rs_valid = 2'b00;

    // Resolve beats a simultaneous lookup; lookup waits until after UP_WR.
    gnt_q.push_back(4'b1000); rd_q.push_back(5'b10000); pred_q.push_back(4'b1000);
    req(0, 1, 2'b00, 2'b00);
    settle(2);
    gnt_q.push_back(4'b0010); rd_q.push_back(5'b10000); wr_q.push_back({5'b10000, 2'b01});
    gnt_q.push_back(4'b0100); rd_q.push_back(5'b00110); pred_q.push_back(4'b0100);
    req(1, 0, 2'b10, 2'b10);
    settle(2);
    chk("mp_after_t1_resolve", mispredict_cnt, 32'h0001_0001);

    // Both threads requesting: grants alternate T1, T0, T1.
    gnt_q.push_back(4'b1000); rd_q.push_back(5'b10001); pred_q.push_back(4'b1000);
    gnt_q.push_back(4'b0100); rd_q.push_back(5'b00110); pred_q.push_back(4'b0100);
    gnt_q.push_back(4'b1000); rd_q.push_back(5'b10001); pred_q.push_back(4'b1000);
    req(1, 2, 2'b00, 2'b00);
    settle(2);

    // Fill T0 queue to 4 entries; T0 then stalls while T1 is still served.
    gnt_q.push_back(4'b0100); rd_q.push_back(5'b00110); pred_q.push_back(4'b0100);
    gnt_q.push_back(4'b0100); rd_q.push_back(5'b00110); pred_q.push_back(4'b0100);
    req(2, 0, 2'b00, 2'b00);
    settle(2);
    hold_lk = 2'b01;
    lk_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lk_stall_full", lk_ready, 2'b00);
      @(posedge clk);
      #1;
    end
    gnt_q.push_back(4'b1000); rd_q.push_back(5'b10001); pred_q.push_back(4'b1000);
    req(0, 1, 2'b00, 2'b00);
    settle(3);
    hold_lk = 2'b00;
    lk_valid = 2'b00;
`ifdef BP_SCHED_STATS_EN
    chk("lookup_cnt", lookup_cnt, 32'h0004_0007);
`else
    chk("lookup_cnt", lookup_cnt, 32'h0000_0000);
`endif
    chk("mp_before_abort", mispredict_cnt, 32'h0001_0001);

    // Reset asserted during UP_RD: no write, everything cleared.
    gnt_q.push_back(4'b0001); rd_q.push_back(5'b00110);
    req(0, 0, 2'b01, 2'b01);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_outputs_zero("abort");
    settle(2);
    chk("abort_no_we", tbl_we, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    settle(1);
    hold_rs = 2'b11;
    rs_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rs_stall_after_abort", rs_ready, 2'b00);
      @(posedge clk);
      #1;
    end
    hold_rs = 2'b00;
    rs_valid = 2'b00;
    // History cleared to 0; table contents were kept.
    gnt_q.push_back(4'b0100); rd_q.push_back(5'b00000); pred_q.push_back(4'b0100);
    req(1, 0, 2'b00, 2'b00);
    settle(2);
    gnt_q.push_back(4'b1000); rd_q.push_back(5'b10000); pred_q.push_back(4'b1000);
    req(0, 1, 2'b00, 2'b00);
    settle(3);
`ifdef BP_SCHED_STATS_EN
    chk("lookup_cnt_after_abort", lookup_cnt, 32'h0001_0001);
`else
    chk("lookup_cnt_after_abort", lookup_cnt, 32'h0000_0000);
`endif
    chk("mp_after_abort", mispredict_cnt, 32'h0000_0000);

    // Every expected event must have been observed.
    chk("gnt_q_left", gnt_q.size(), 0);
    chk("pred_q_left", pred_q.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
